mem_req_scheduler: RTL

MEM_REQ_SCHEDULER -- requirements
Module: mem_req_scheduler

---
 rtl/mem_pkg.sv | 22 ++
 rtl/rd_valid_pipe.sv | 32 +++
 rtl/mem_req_scheduler.sv | 109 ++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared constants and request type for the two-port memory request scheduler.
package mem_pkg;

  localparam int unsigned BANK_SEL_W = 2;
  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 4;
  localparam int unsigned REQ_ADDR_W = 8;
  localparam int unsigned REQ_DATA_W = 12;

  typedef struct packed {
    logic                  we;
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_DATA_W-1:0] wdata;
  } mem_req_t;

  function automatic int unsigned clamp_latency(input int unsigned lat);
    if (lat < RD_LAT_MIN) return RD_LAT_MIN;
    if (lat > RD_LAT_MAX) return RD_LAT_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/rd_valid_pipe.sv
// Read-valid delay line: a read issued on the memory side emerges as valid LATENCY cycles later.
module rd_valid_pipe
  import mem_pkg::*;
#(
  parameter int unsigned LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic issue,
  output logic valid
);

  localparam int unsigned DEPTH = clamp_latency(LATENCY);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else begin
      sr[0] <= issue;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  always_comb begin
    valid = sr[DEPTH-1];
  end

endmodule

// File: rtl/mem_req_scheduler.sv
// Two-requester front end for a dual-port memory: round-robin arbitration on
// same-address hazards, registered issue, and per-port read-valid tracking.
module mem_req_scheduler #(
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_a,
  input  logic              i_we_a,
  input  logic [ADDR_W-1:0] i_addr_a,
  input  logic [DATA_W-1:0] i_wdata_a,
  output logic              o_gnt_a,
  output logic              o_rvalid_a,
  output logic [DATA_W-1:0] o_rdata_a,
  input  logic              i_req_b,
  input  logic              i_we_b,
  input  logic [ADDR_W-1:0] i_addr_b,
  input  logic [DATA_W-1:0] i_wdata_b,
  output logic              o_gnt_b,
  output logic              o_rvalid_b,
  output logic [DATA_W-1:0] o_rdata_b,
  output logic              o_en_a,
  output logic              o_we_a,
  output logic [ADDR_W-1:0] o_addr_a,
  output logic [DATA_W-1:0] o_din_a,
  input  logic [DATA_W-1:0] i_dout_a,
  output logic              o_en_b,
  output logic              o_we_b,
  output logic [ADDR_W-1:0] o_addr_b,
  output logic [DATA_W-1:0] o_din_b,
  input  logic [DATA_W-1:0] i_dout_b,
  output logic [CNT_W-1:0]  o_conflict_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic collision;
  logic ptr_q;

  // Only a same-address pair involving a write is a hazard; read/read and
  // same-bank/different-address pairs go through together.
  always_comb begin
    collision = i_req_a & i_req_b & (i_addr_a == i_addr_b) & (i_we_a | i_we_b);
    o_gnt_a   = ~rst & i_req_a & (~collision | ~ptr_q);
    o_gnt_b   = ~rst & i_req_b & (~collision | ptr_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q          <= 1'b0;
      o_conflict_cnt <= '0;
    end else if (collision) begin
      ptr_q <= ~ptr_q;
      if (o_conflict_cnt != '1) begin
        o_conflict_cnt <= o_conflict_cnt + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_en_a   <= 1'b0;
      o_we_a   <= 1'b0;
      o_addr_a <= '0;
      o_din_a  <= '0;
      o_en_b   <= 1'b0;
      o_we_b   <= 1'b0;
      o_addr_b <= '0;
      o_din_b  <= '0;
    end else begin
      o_en_a <= o_gnt_a;
      o_we_a <= o_gnt_a & i_we_a;
      o_en_b <= o_gnt_b;
      o_we_b <= o_gnt_b & i_we_b;
      if (o_gnt_a) begin
        o_addr_a <= i_addr_a;
        o_din_a  <= i_wdata_a;
      end
      if (o_gnt_b) begin
        o_addr_b <= i_addr_b;
        o_din_b  <= i_wdata_b;
      end
    end
  end

  rd_valid_pipe #(.LATENCY(RD_LATENCY)) u_rd_pipe_a (
    .clk   (clk),
    .rst   (rst),
    .issue (o_en_a & ~o_we_a),
    .valid (o_rvalid_a)
  );

  rd_valid_pipe #(.LATENCY(RD_LATENCY)) u_rd_pipe_b (
    .clk   (clk),
    .rst   (rst),
    .issue (o_en_b & ~o_we_b),
    .valid (o_rvalid_b)
  );

  // Read data is a straight passthrough, forced to zero only while in reset.
  always_comb begin
    o_rdata_a = rst ? '0 : i_dout_a;
    o_rdata_b = rst ? '0 : i_dout_b;
  end

endmodule
